// File: rtl/reg_bus_master_if.sv
// reg_bus_master_if: command, response and register-bus signals of reg_bus_master
interface reg_bus_master_if #(parameter int DATA_WIDTH = 8);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [DATA_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  busy;
  logic                  read_flag;
  logic                  write_flag;
  logic [DATA_WIDTH-1:0] amba_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [DATA_WIDTH-1:0] bus_rdata;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, bus_rdata,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, busy, read_flag, write_flag, amba_addr, bus_wdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, bus_rdata,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, busy, read_flag, write_flag, amba_addr, bus_wdata
  );
endinterface

// File: rtl/reg_bus_master.sv
// reg_bus_master: FIFO-buffered command initiator for the register bank bus
module reg_bus_master #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic SYS_CLK,
  input logic rst,
  reg_bus_master_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 2 * DATA_WIDTH + 1;
  typedef enum logic [2:0] {IDLE, WRITE, READ, READ_WAIT, RESP} state_t;
  state_t                state_q, state_d;
  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [EW-1:0]         mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic                  rsp_write_q, rsp_write_d;
  logic                  push, pop;
  logic [EW-1:0]         head;
  assign bus.cmd_ready  = count_q != (PW+1)'(FIFO_DEPTH);
  assign push           = bus.cmd_valid && bus.cmd_ready;
  assign pop            = state_q == IDLE && count_q != '0;
  assign head           = mem_q[rd_ptr_q];
  assign bus.read_flag  = state_q == READ;
  assign bus.write_flag = state_q == WRITE;
  assign bus.rsp_valid  = state_q == RESP;
  assign bus.amba_addr  = addr_q;
  assign bus.bus_wdata  = wdata_q;
  assign bus.rsp_write  = rsp_write_q;
  assign bus.rsp_rdata  = rdata_q;
  assign bus.busy       = count_q != '0 || state_q != IDLE;
  // Command FIFO: store on push, advance pointers and occupancy
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  // Transaction sequencing: pop, strobe, capture read data, hold response
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_write_d = rsp_write_q;
    case (state_q)
      IDLE: if (pop) begin
        addr_d  = head[EW-2:DATA_WIDTH];
        wdata_d = head[DATA_WIDTH-1:0];
        state_d = head[EW-1] ? WRITE : READ;
      end
      WRITE: begin
        rsp_write_d = 1'b1;
        rdata_d     = '0;
        state_d     = RESP;
      end
      READ: state_d = READ_WAIT;
      READ_WAIT: begin
        rsp_write_d = 1'b0;
        rdata_d     = bus.bus_rdata;
        state_d     = RESP;
      end
      RESP: state_d = bus.rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // Control and datapath registers with synchronous flush
  always_ff @(posedge SYS_CLK) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_write_q <= rsp_write_d;
    end
  end
  // FIFO storage needs no reset; entries are only read behind the write pointer
  always_ff @(posedge SYS_CLK) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master: directed and random self-checking bench for reg_bus_master
module tb_reg_bus_master;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  reg_bus_master_if #(.DATA_WIDTH(8)) bus();
  reg_bus_master #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (.SYS_CLK(clk), .rst(rst), .bus(bus));
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, last_strobe = -10, n_push = 0, n_strobe = 0, n_rsp = 0;
  logic [7:0]  regs [256];
  logic [16:0] expq [$];
  logic [8:0]  rspq [$];
  logic [7:0]  rd_log [$];
  logic [16:0] e;
  logic [8:0]  r;
  logic        stall = 1'b0;
  logic [8:0]  stall_val;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
    logic acc;
    acc = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    for (int k = 0; k < 100; k++) begin
      acc = bus.cmd_ready;
      tick();
      if (acc) break;
    end
    chk("push_accept", {31'd0, acc}, 32'd1);
  endtask
  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (!bus.busy && !bus.rsp_valid) break;
      tick();
    end
    chk("drain_busy", {31'd0, bus.busy}, 32'd0);
    chk("drain_expq", expq.size(), 32'd0);
    chk("drain_rspq", rspq.size(), 32'd0);
  endtask
  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rflag"}, {31'd0, bus.read_flag}, 32'd0);
    chk({tag, "_wflag"}, {31'd0, bus.write_flag}, 32'd0);
    chk({tag, "_addr"}, {24'd0, bus.amba_addr}, 32'd0);
    chk({tag, "_wdata"}, {24'd0, bus.bus_wdata}, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, bus.rsp_valid}, 32'd0);
    chk({tag, "_rwrite"}, {31'd0, bus.rsp_write}, 32'd0);
    chk({tag, "_rdata"}, {24'd0, bus.rsp_rdata}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
      regs[5] <= 8'h3C;
      bus.bus_rdata <= 8'h00;
    end else begin
      if (bus.write_flag) regs[bus.amba_addr] <= bus.bus_wdata;
      bus.bus_rdata <= bus.read_flag ? regs[bus.amba_addr] : 8'h00;
    end
  end
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      expq.delete();
      rspq.delete();
      stall = 1'b0;
      last_strobe = -10;
    end else begin
      if (bus.read_flag || bus.write_flag) begin
        n_strobe++;
        chk("flag_excl", {31'd0, bus.read_flag & bus.write_flag}, 32'd0);
        chk("strobe_gap", {31'd0, (cyc - last_strobe) >= 2}, 32'd1);
        last_strobe = cyc;
        chk("strobe_known", {31'd0, expq.size() != 0}, 32'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("strobe_kind", {31'd0, bus.write_flag}, {31'd0, e[16]});
          chk("strobe_addr", {24'd0, bus.amba_addr}, {24'd0, e[15:8]});
          if (bus.write_flag) chk("strobe_wdata", {24'd0, bus.bus_wdata}, {24'd0, e[7:0]});
          rspq.push_back(bus.write_flag ? 9'h100 : {1'b0, regs[bus.amba_addr]});
        end
      end
      if (stall) begin
        chk("rsp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("rsp_hold_data", {23'd0, bus.rsp_write, bus.rsp_rdata}, {23'd0, stall_val});
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_rsp++;
        chk("rsp_known", {31'd0, rspq.size() != 0}, 32'd1);
        if (rspq.size() != 0) begin
          r = rspq.pop_front();
          chk("rsp_write", {31'd0, bus.rsp_write}, {31'd0, r[8]});
          chk("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, r[7:0]});
        end
        if (!bus.rsp_write) rd_log.push_back(bus.rsp_rdata);
      end
      stall = bus.rsp_valid && !bus.rsp_ready;
      stall_val = {bus.rsp_write, bus.rsp_rdata};
      if (bus.cmd_valid && bus.cmd_ready) begin
        n_push++;
        expq.push_back({bus.cmd_write, bus.cmd_addr, bus.cmd_wdata});
      end
    end
  end
  initial begin
    int p0, s0, r0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_wdata = 8'h00;
    bus.rsp_ready = 1'b0;
    repeat (3) tick();
    chk_zero_outputs("rst");
    rst = 1'b0;
    tick();
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h05;
    tick();
    bus.cmd_valid = 1'b0;
    chk("rd_e0_flag", {31'd0, bus.read_flag}, 32'd0);
    chk("rd_e0_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    chk("rd_flag", {31'd0, bus.read_flag}, 32'd1);
    chk("rd_no_wflag", {31'd0, bus.write_flag}, 32'd0);
    chk("rd_addr", {24'd0, bus.amba_addr}, 32'h05);
    tick();
    chk("rd_wait_flag", {31'd0, bus.read_flag}, 32'd0);
    chk("rd_wait_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rd_wait_addr", {24'd0, bus.amba_addr}, 32'h05);
    tick();
    chk("rd_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("rd_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'h3C);
    chk("rd_rsp_write", {31'd0, bus.rsp_write}, 32'd0);
    tick();
    chk("rd_rsp_stall", {31'd0, bus.rsp_valid}, 32'd1);
    bus.rsp_ready = 1'b1;
    tick();
    chk("rd_rsp_done", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rd_idle_busy", {31'd0, bus.busy}, 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h05;
    bus.cmd_wdata = 8'hA5;
    tick();
    bus.cmd_valid = 1'b0;
    chk("wr_e0_flag", {31'd0, bus.write_flag}, 32'd0);
    tick();
    chk("wr_flag", {31'd0, bus.write_flag}, 32'd1);
    chk("wr_no_rflag", {31'd0, bus.read_flag}, 32'd0);
    chk("wr_addr", {24'd0, bus.amba_addr}, 32'h05);
    chk("wr_wdata", {24'd0, bus.bus_wdata}, 32'hA5);
    tick();
    chk("wr_flag_off", {31'd0, bus.write_flag}, 32'd0);
    chk("wr_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("wr_rsp_write", {31'd0, bus.rsp_write}, 32'd1);
    chk("wr_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'h00);
    tick();
    chk("wr_rsp_done", {31'd0, bus.rsp_valid}, 32'd0);
    bus.rsp_ready = 1'b0;
    r0 = n_rsp;
    for (int i = 0; i < 5; i++) begin
      push(i % 2 == 0, 8'(8'h10 + i), 8'(8'h50 + i));
      if (i == 3) chk("full_ready_4", {31'd0, bus.cmd_ready}, 32'd1);
    end
    chk("full_ready_5", {31'd0, bus.cmd_ready}, 32'd0);
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h15;
    bus.cmd_wdata = 8'h55;
    repeat (3) tick();
    chk("full_still", {31'd0, bus.cmd_ready}, 32'd0);
    chk("full_stalled", {31'd0, bus.rsp_valid}, 32'd1);
    bus.rsp_ready = 1'b1;
    push(1'b1, 8'h15, 8'h55);
    bus.cmd_valid = 1'b0;
    drain();
    chk("full_rsp_count", n_rsp - r0, 32'd6);
    rd_log.delete();
    s0 = n_strobe;
    for (int i = 1; i <= 8; i++)
      push(i % 2 == 1, 8'(i % 2 == 1 ? i : i - 1), 8'(8'hB0 + i));
    bus.cmd_valid = 1'b0;
    drain();
    chk("wrap_strobes", n_strobe - s0, 32'd8);
    chk("wrap_reads", rd_log.size(), 32'd4);
    for (int j = 0; j < 4; j++) chk("wrap_rdata", {24'd0, rd_log[j]}, 32'hB1 + 32'(2 * j));
    push(1'b0, 8'h03, 8'hEE);
    push(1'b1, 8'h20, 8'h77);
    push(1'b0, 8'h21, 8'h00);
    chk("rm_pre_addr", {24'd0, bus.amba_addr}, 32'h03);
    chk("rm_pre_valid", {31'd0, bus.rsp_valid}, 32'd0);
    rst = 1'b1;
    tick();
    chk_zero_outputs("rm");
    chk("rm_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    r0 = n_rsp;
    repeat (10) tick();
    chk("rm_no_rsp", n_rsp - r0, 32'd0);
    chk("rm_busy", {31'd0, bus.busy}, 32'd0);
    p0 = n_push;
    s0 = n_strobe;
    r0 = n_rsp;
    for (int c = 0; c < 1000; c++) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_write = 1'($urandom_range(0, 1));
      bus.cmd_addr  = 8'($urandom_range(0, 15));
      bus.cmd_wdata = 8'($urandom);
      bus.rsp_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    drain();
    chk("rand_activity", {31'd0, (n_push - p0) > 20}, 32'd1);
    chk("rand_strobes", n_strobe - s0, n_push - p0);
    chk("rand_rsps", n_rsp - r0, n_push - p0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
